// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter.
// FSM state codes, port ids and default bus widths.
package mem_arbiter_pkg;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_AWIDTH = 12;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter.
// master = requesters + memory, slave = arbiter.
interface mem_arbiter_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [AWIDTH-1:0] addr0;
    logic [AWIDTH-1:0] addr1;
    logic [DWIDTH-1:0] wdata0;
    logic [DWIDTH-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DWIDTH-1:0] rdata;
    logic              mem_load;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_d;
    logic [DWIDTH-1:0] mem_q;

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_load, mem_addr, mem_d
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_load, mem_addr, mem_d
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Idle-state winner selection for the two-port arbiter.
// MEM_ARB_FIXED_PRI_EN: port 0 always wins; default round-robin.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

`ifdef MEM_ARB_FIXED_PRI_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // Choose the port to grant when nobody owns the memory
    always_comb begin
        valid = req0 | req1;
`ifdef MEM_ARB_FIXED_PRI_EN
        winner = req0 ? PORT0 : PORT1;
`else
        if (req0 && req1) winner = ~last;
        else              winner = req1 ? PORT1 : PORT0;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a 1-cycle-latency single-port memory.
// Optional MEM_ARB_FIXED_PRI_EN selects fixed port-0 priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last;
    logic              pick_w;
    logic              pick_v;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              mem_load_c;
    logic [AWIDTH-1:0] mem_addr_c;
    logic [DWIDTH-1:0] mem_d_c;

    mem_arb_pick u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last),
        .winner (pick_w),
        .valid  (pick_v)
    );

    // Grant and next-state decode; nothing is granted during reset
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (pick_v && pick_w == PORT1) begin
                        gnt1      = 1'b1;
                        state_nxt = bus.lock1 ? ST_OWN1 : ST_IDLE;
                    end else if (pick_v) begin
                        gnt0      = 1'b1;
                        state_nxt = bus.lock0 ? ST_OWN0 : ST_IDLE;
                    end
                end
                ST_OWN0: begin
                    gnt0      = bus.req0;
                    state_nxt = (bus.req0 && bus.lock0) ? ST_OWN0 : ST_IDLE;
                end
                ST_OWN1: begin
                    gnt1      = bus.req1;
                    state_nxt = (bus.req1 && bus.lock1) ? ST_OWN1 : ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= PORT1;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && pick_v) last <= pick_w;
        end
    end

    // Read-return valids, one cycle after a read is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~bus.we0;
            rvalid1_q <= gnt1 & ~bus.we1;
        end
    end

    // Drive the memory from the granted port, zeros when idle
    always_comb begin
        mem_load_c = 1'b0;
        mem_addr_c = '0;
        mem_d_c    = '0;
        if (gnt0) begin
            mem_load_c = bus.we0;
            mem_addr_c = bus.addr0;
            mem_d_c    = bus.wdata0;
        end else if (gnt1) begin
            mem_load_c = bus.we1;
            mem_addr_c = bus.addr1;
            mem_d_c    = bus.wdata1;
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata    = bus.mem_q;
    assign bus.mem_load = mem_load_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.mem_d    = mem_d_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus
// randomized traffic against a behavioural ownership/memory model.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 12;
`ifdef MEM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous single-port memory, read-first, 1-cycle latency
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] mem_q_r;
    assign bus.mem_q = mem_q_r;
    always @(posedge clk) begin
        if (bus.mem_load) mem[bus.mem_addr] <= bus.mem_d;
        mem_q_r <= mem[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural model: who owns the memory, who won last, what read is due
    int            m_owner = -1;
    bit            m_last  = 1'b1;
    bit            m_pv0   = 1'b0;
    bit            m_pv1   = 1'b0;
    logic [DW-1:0] m_pd;
    logic [DW-1:0] ref_mem [0:4095];
    logic          sg0 = 1'b0;
    logic          sg1 = 1'b0;

    always @(negedge clk) begin : model
        bit            g;
        int            w;
        logic          e_we;
        logic          e_lk;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_d;
        g = 1'b0;
        w = 0;
        if (!reset) begin
            if (m_owner < 0) begin
                if (bus.req0 && bus.req1) begin
                    g = 1'b1;
                    w = (FIXED || m_last) ? 0 : 1;
                end else if (bus.req0) begin
                    g = 1'b1;
                    w = 0;
                end else if (bus.req1) begin
                    g = 1'b1;
                    w = 1;
                end
            end else if (m_owner == 0) begin
                g = bus.req0;
                w = 0;
            end else begin
                g = bus.req1;
                w = 1;
            end
        end
        e_we   = (w == 1) ? bus.we1    : bus.we0;
        e_lk   = (w == 1) ? bus.lock1  : bus.lock0;
        e_addr = (w == 1) ? bus.addr1  : bus.addr0;
        e_d    = (w == 1) ? bus.wdata1 : bus.wdata0;

        chk("gnt0", 32'(bus.gnt0), 32'(g && w == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(g && w == 1));
        chk("mem_load", 32'(bus.mem_load), 32'(g ? e_we : 1'b0));
        chk("mem_addr", 32'(bus.mem_addr), 32'(g ? e_addr : '0));
        chk("mem_d", 32'(bus.mem_d), 32'(g ? e_d : '0));
        chk("rvalid0", 32'(bus.rvalid0), 32'(m_pv0));
        chk("rvalid1", 32'(bus.rvalid1), 32'(m_pv1));
        if (m_pv0 || m_pv1) chk("rdata", 32'(bus.rdata), 32'(m_pd));

        sg0 = bus.gnt0;
        sg1 = bus.gnt1;

        if (reset) begin
            m_owner = -1;
            m_last  = 1'b1;
            m_pv0   = 1'b0;
            m_pv1   = 1'b0;
        end else begin
            m_pv0 = g && w == 0 && !e_we;
            m_pv1 = g && w == 1 && !e_we;
            if (g && !e_we) m_pd = ref_mem[e_addr];
            if (g && e_we)  ref_mem[e_addr] = e_d;
            if (m_owner < 0 && g) m_last = (w == 1);
            m_owner = (g && e_lk) ? w : -1;
        end
    end

    task automatic new_req(input int p);
        logic          we;
        logic          lk;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        we = ($urandom_range(0, 2) == 0);
        lk = ($urandom_range(0, 3) == 0);
        a  = AW'($urandom_range(0, 31));
        d  = DW'($urandom);
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.lock0 = lk;
            bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.lock1 = lk;
            bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Drop each request once served; bounded
    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (!bus.req0 && !bus.req1) break;
            @(posedge clk); #1;
            if (sg0) bus.req0 = 1'b0;
            if (sg1) bus.req1 = 1'b0;
            @(negedge clk);
        end
        chk("drain_bound", 32'({bus.req0, bus.req1}), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = DW'(i);
            ref_mem[i] = DW'(i);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b0;
        bus.addr0 = '0;  bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0;
        bus.addr1 = '0;  bus.wdata1 = '0;

        // 1: reset holds off grants
        repeat (2) begin
            @(negedge clk);
            chk("t1_rst_gnt0", 32'(bus.gnt0), 32'd0);
            chk("t1_rst_rv0", 32'(bus.rvalid0), 32'd0);
            chk("t1_rst_rv1", 32'(bus.rvalid1), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1_gnt0", 32'(bus.gnt0), 32'd1);

        // 2: read addr 5
        @(posedge clk); #1;
        bus.addr0 = AW'(5);
        @(negedge clk);
        chk("t2_gnt0", 32'(bus.gnt0), 32'd1);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("t2_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("t2_rdata", 32'(bus.rdata), 32'd5);

        // 4: locked burst on port 1 while port 0 waits
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.req1  = 1'b1;
            bus.we1   = 1'b0;
            bus.addr1 = AW'(10 + k);
            bus.lock1 = (k < 3);
            if (k == 1) begin
                bus.req0 = 1'b1; bus.we0 = 1'b0;
                bus.lock0 = 1'b0; bus.addr0 = AW'(20);
            end
            @(negedge clk);
            chk("t4_gnt1", 32'(bus.gnt1), 32'd1);
            chk("t4_gnt0", 32'(bus.gnt0), 32'd0);
            if (k > 0) begin
                chk("t4_rvalid1", 32'(bus.rvalid1), 32'd1);
                chk("t4_rdata", 32'(bus.rdata), 32'(10 + k - 1));
            end
        end

        // 3: both requesting, no lock
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                bus.addr1 = AW'(14);
                bus.lock1 = 1'b0;
            end else begin
                if (sg0) bus.addr0 = bus.addr0 + AW'(1);
                if (sg1) bus.addr1 = bus.addr1 + AW'(1);
            end
            @(negedge clk);
            if (k == 0) begin
                chk("t4_last_rv1", 32'(bus.rvalid1), 32'd1);
                chk("t4_last_rdata", 32'(bus.rdata), 32'd13);
            end
            chk("t3_gnt0", 32'(bus.gnt0), 32'(FIXED || (k % 2 == 0)));
            chk("t3_gnt1", 32'(bus.gnt1), 32'(!FIXED && (k % 2 == 1)));
        end
        drain();

        // 5: write then read-back
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.lock0 = 1'b0;
        bus.addr0 = AW'(7); bus.wdata0 = 16'hBEEF;
        @(negedge clk);
        chk("t5_wr_gnt0", 32'(bus.gnt0), 32'd1);
        @(posedge clk); #1;
        bus.we0 = 1'b0;
        @(negedge clk);
        chk("t5_rd_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t5_wr_norv", 32'(bus.rvalid0), 32'd0);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("t5_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("t5_rdata", 32'(bus.rdata), 32'hBEEF);

        // 6: reset in the middle of a port-1 burst
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b1;
        bus.addr1 = AW'(30);
        @(negedge clk);
        chk("t6_gnt1", 32'(bus.gnt1), 32'd1);
        @(posedge clk); #1;
        bus.addr1 = AW'(31);
        @(negedge clk);
        chk("t6_own_gnt1", 32'(bus.gnt1), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.addr1 = AW'(32);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b0;
        bus.addr0 = AW'(40);
        @(negedge clk);
        chk("t6_rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("t6_rst_gnt1", 32'(bus.gnt1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("t6_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t6_gnt1", 32'(bus.gnt1), 32'd0);
        drain();

        // Random traffic, occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            if (!bus.req0 || sg0) begin
                if ($urandom_range(0, 9) < 6) new_req(0);
                else bus.req0 = 1'b0;
            end
            if (!bus.req1 || sg1) begin
                if ($urandom_range(0, 9) < 6) new_req(1);
                else bus.req1 = 1'b0;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        drain();

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
